// File: rtl/pe_alu_seq.sv
// pe_alu_seq: handshaked sequential ALU for the PE tile.
// add/sub/and/or/xor complete in one cycle. mul is an iterative shift-add on
// operand magnitudes and returns the full 2*WIDTH product as {out_y_hi, out_y}.
// Optional build macro: PE_ALU_FLAGS_EN adds the out_zero/out_carry/out_ovf
// outputs, registered alongside the result.
module pe_alu_seq #(
  parameter int WIDTH = 8,
  parameter int OPC_W = 3
) (
  input  logic             UserCLK,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPC_W-1:0] in_op,
  input  logic             in_a_signed,
  input  logic             in_b_signed,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [WIDTH-1:0] out_y_hi,
  output logic             out_err
`ifdef PE_ALU_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_carry,
  output logic             out_ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_AND = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_OR  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_XOR = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_MUL = OPC_W'(5);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_OUT} state_e;

  state_e               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_a_mag;
  logic [WIDTH-1:0]     r_b_mag;
  logic                 r_neg;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_y;
  logic [WIDTH-1:0]     r_y_hi;
  logic                 r_err;

  logic                 w_accept;
  logic                 w_is_mul;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH-1:0]     w_sum;
  logic [WIDTH-1:0]     w_diff;
  logic [WIDTH-1:0]     w_lo;
  logic                 w_err;
  logic [2*WIDTH-1:0]   w_addend;
  logic [2*WIDTH-1:0]   w_prod;
  logic [2*WIDTH-1:0]   w_final;
  logic                 w_last;

  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_OUT) && out_ready);
  assign out_valid = (r_state == S_OUT);
  assign out_y     = r_y;
  assign out_y_hi  = r_y_hi;
  assign out_err   = r_err;

  assign w_accept = in_valid && in_ready;
  assign w_is_mul = (in_op == OP_MUL);

  // Magnitudes: the most-negative value negates to itself, which read as
  // unsigned is exactly 2^(WIDTH-1).
  assign w_a_neg = in_a_signed && in_a[WIDTH-1];
  assign w_b_neg = in_b_signed && in_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -in_a : in_a;
  assign w_b_mag = w_b_neg ? -in_b : in_b;

  assign w_sum  = in_a + in_b;
  assign w_diff = in_a - in_b;

  // Single-cycle result selection for the non-multiply opcodes.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_lo  = '0;
    w_err = 1'b0;
    case (in_op)
      OP_ADD:  w_lo = w_sum;
      OP_SUB:  w_lo = w_diff;
      OP_AND:  w_lo = in_a & in_b;
      OP_OR:   w_lo = in_a | in_b;
      OP_XOR:  w_lo = in_a ^ in_b;
      OP_MUL:  w_lo = '0;
      default: w_err = 1'b1;
    endcase
  end

  // One shift-add step per MUL cycle; the last step is folded into finalisation.
  assign w_addend = r_b_mag[r_cnt] ? ((2*WIDTH)'(r_a_mag) << r_cnt) : '0;
  assign w_prod   = r_acc + w_addend;
  assign w_final  = r_neg ? -w_prod : w_prod;
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef PE_ALU_FLAGS_EN
  logic               r_zero;
  logic               r_carry;
  logic               r_ovf;
  logic               r_prod_signed;
  logic               w_both_signed;
  logic               w_zero;
  logic               w_carry;
  logic               w_ovf;
  logic [WIDTH:0]     w_hi_ext;
  logic               w_mul_ovf;

  assign out_zero  = r_zero;
  assign out_carry = r_carry;
  assign out_ovf   = r_ovf;

  assign w_both_signed = in_a_signed && in_b_signed;
  // A signed product fits in WIDTH bits when its top WIDTH+1 bits are all equal;
  // an unsigned one fits when its upper half is zero.
  assign w_hi_ext  = w_final[2*WIDTH-1:WIDTH-1];
  assign w_mul_ovf = r_prod_signed ? !((&w_hi_ext) || !(|w_hi_ext))
                                   : (|w_final[2*WIDTH-1:WIDTH]);

  // Status flags for the single-cycle opcodes.
  always_comb begin
    w_zero  = (w_lo == '0);
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (in_op)
      OP_ADD: begin
        w_carry = (w_sum < in_a);
        w_ovf   = w_both_signed && (in_a[WIDTH-1] == in_b[WIDTH-1])
                  && (w_sum[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_carry = (in_a >= in_b);
        w_ovf   = w_both_signed && (in_a[WIDTH-1] != in_b[WIDTH-1])
                  && (w_diff[WIDTH-1] != in_a[WIDTH-1]);
      end
      default: ;
    endcase
  end
`endif

  // Control state and registered result; reset dominates every other event.
  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge UserCLK) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_y     <= '0;
      r_y_hi  <= '0;
      r_err   <= 1'b0;
`ifdef PE_ALU_FLAGS_EN
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_OUT: begin
          if (w_accept) begin
            if (w_is_mul) begin
              r_state <= S_MUL;
              r_cnt   <= '0;
            end else begin
              r_state <= S_OUT;
              r_y     <= w_lo;
              r_y_hi  <= '0;
              r_err   <= w_err;
`ifdef PE_ALU_FLAGS_EN
              r_zero  <= w_zero;
              r_carry <= w_carry;
              r_ovf   <= w_ovf;
`endif
            end
          end else if ((r_state == S_OUT) && out_ready) begin
            r_state <= S_IDLE;
          end
        end
        S_MUL: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= S_OUT;
            r_y     <= w_final[WIDTH-1:0];
            r_y_hi  <= w_final[2*WIDTH-1:WIDTH];
            r_err   <= 1'b0;
`ifdef PE_ALU_FLAGS_EN
            r_zero  <= (w_final == '0);
            r_carry <= 1'b0;
            r_ovf   <= w_mul_ovf;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Multiplier operands and accumulator: loaded on a mul accept, stepped in MUL.
  // NOTE: datapath registers carry no reset; they are always loaded before use.
  always_ff @(posedge UserCLK) begin
    if (w_accept && w_is_mul) begin
      r_a_mag <= w_a_mag;
      r_b_mag <= w_b_mag;
      r_neg   <= w_a_neg ^ w_b_neg;
      r_acc   <= '0;
`ifdef PE_ALU_FLAGS_EN
      r_prod_signed <= in_a_signed || in_b_signed;
`endif
    end else if (r_state == S_MUL) begin
      r_acc <= w_prod;
    end
  end

endmodule

// File: tb/tb_pe_alu_seq.sv
// Self-checking bench for pe_alu_seq (WIDTH=8): directed cases plus random
// traffic compared against an arithmetic reference model with a latency counter.
module tb_pe_alu_seq;

  localparam int WIDTH = 8;
  localparam int OPC_W = 3;

  logic             UserCLK = 1'b0;
  logic             resetn = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [OPC_W-1:0] in_op = '0;
  logic             in_a_signed = 1'b0;
  logic             in_b_signed = 1'b0;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_y;
  logic [WIDTH-1:0] out_y_hi;
  logic             out_err;
`ifdef PE_ALU_FLAGS_EN
  logic             out_zero;
  logic             out_carry;
  logic             out_ovf;
`endif

  always #5 UserCLK = ~UserCLK;

  pe_alu_seq #(.WIDTH(WIDTH), .OPC_W(OPC_W)) u_dut (
    .UserCLK     (UserCLK),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a_signed (in_a_signed),
    .in_b_signed (in_b_signed),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_y       (out_y),
    .out_y_hi    (out_y_hi),
    .out_err     (out_err)
`ifdef PE_ALU_FLAGS_EN
    ,
    .out_zero    (out_zero),
    .out_carry   (out_carry),
    .out_ovf     (out_ovf)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: one pending result and the number of edges until it shows.
  bit               m_hold = 1'b0;
  int               m_wait = 0;
  logic [WIDTH-1:0] e_y, e_hi;
  logic             e_err, e_zero, e_carry, e_ovf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit m_ready();
    return !m_hold || (m_wait == 0 && out_ready);
  endfunction

  // Result of one operation straight from the arithmetic definitions.
  function automatic void ref_op(input logic [2:0] op, input bit as, input bit bs,
                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 output logic [WIDTH-1:0] y, output logic [WIDTH-1:0] hi,
                                 output logic err, output logic z, output logic c,
                                 output logic v);
    longint lim  = longint'(1) << WIDTH;
    longint smax = (lim / 2) - 1;
    longint smin = -(lim / 2);
    longint ua   = longint'(a);
    longint ub   = longint'(b);
    longint sa   = (as && a[WIDTH-1]) ? ua - lim : ua;
    longint sb   = (bs && b[WIDTH-1]) ? ub - lim : ub;
    longint r;
    y = '0; hi = '0; err = 1'b0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin
        r = ua + ub;  y = r[WIDTH-1:0];  c = (r >= lim);
        v = as && bs && ((sa + sb) > smax || (sa + sb) < smin);
      end
      3'd1: begin
        r = ua - ub;  y = r[WIDTH-1:0];  c = (ua >= ub);
        v = as && bs && ((sa - sb) > smax || (sa - sb) < smin);
      end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd5: begin
        r  = sa * sb;
        y  = r[WIDTH-1:0];
        hi = r[2*WIDTH-1:WIDTH];
        v  = (as || bs) ? (r > smax || r < smin) : (r > lim - 1);
      end
      default: err = 1'b1;
    endcase
    z = (y == '0) && (hi == '0);
  endfunction

  task automatic drive(input bit v, input logic [2:0] op, input bit as, input bit bs,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit ordy);
    in_valid = v; in_op = op; in_a_signed = as; in_b_signed = bs;
    in_a = a; in_b = b; out_ready = ordy;
    #1;
    check("in_ready", in_ready, m_ready());
  endtask

  task automatic idle(input bit ordy);
    drive(1'b0, 3'd0, 1'b0, 1'b0, '0, '0, ordy);
  endtask

  // Advance one edge: update the model from the inputs seen at the edge, then
  // compare outputs shortly after.
  task automatic tick();
    bit acc, xfer;
    @(posedge UserCLK);
    if (!resetn) begin
      m_hold = 1'b0;
      m_wait = 0;
    end else begin
      xfer = m_hold && (m_wait == 0) && out_ready;
      acc  = in_valid && m_ready();
      if (acc) begin
        ref_op(in_op, in_a_signed, in_b_signed, in_a, in_b,
               e_y, e_hi, e_err, e_zero, e_carry, e_ovf);
        m_hold = 1'b1;
        m_wait = (in_op == 3'd5) ? WIDTH : 0;
      end else if (xfer) begin
        m_hold = 1'b0;
      end else if (m_hold && m_wait > 0) begin
        m_wait--;
      end
    end
    #1;
    check("out_valid", out_valid, m_hold && (m_wait == 0));
    if (m_hold && m_wait == 0) begin
      check("out_y", out_y, e_y);
      check("out_y_hi", out_y_hi, e_hi);
      check("out_err", out_err, e_err);
`ifdef PE_ALU_FLAGS_EN
      check("out_zero", out_zero, e_zero);
      check("out_carry", out_carry, e_carry);
      check("out_ovf", out_ovf, e_ovf);
`endif
    end
  endtask

  initial begin
    // Reset for two edges, then release.
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    idle(1'b1);
    check("rst_valid", out_valid, 1'b0);
    check("rst_y", out_y, 8'h00);
    check("rst_y_hi", out_y_hi, 8'h00);
    check("rst_err", out_err, 1'b0);
    check("rst_ready", in_ready, 1'b1);

    // add with carry, then back-to-back xor at one op per cycle.
    drive(1'b1, 3'd0, 1'b0, 1'b0, 8'hF0, 8'h20, 1'b1);
    tick();
    check("add_y", out_y, 8'h10);
    check("add_y_hi", out_y_hi, 8'h00);
`ifdef PE_ALU_FLAGS_EN
    check("add_carry", out_carry, 1'b1);
    check("add_zero", out_zero, 1'b0);
`endif
    drive(1'b1, 3'd4, 1'b0, 1'b0, 8'hAA, 8'hFF, 1'b1);
    check("b2b_ready", in_ready, 1'b1);
    tick();
    check("xor_valid", out_valid, 1'b1);
    check("xor_y", out_y, 8'h55);

    // Signed mul -3 * 5; same-cycle drain of the xor result.
    drive(1'b1, 3'd5, 1'b1, 1'b1, 8'hFD, 8'h05, 1'b1);
    tick();
    for (int i = 0; i < WIDTH; i++) begin
      drive(1'b1, 3'($urandom_range(0, 4)), 1'b0, 1'b0, 8'($urandom), 8'($urandom), 1'b1);
      check("mul_busy_ready", in_ready, 1'b0);
      tick();
    end
    check("smul_valid", out_valid, 1'b1);
    check("smul_y", out_y, 8'hF1);
    check("smul_y_hi", out_y_hi, 8'hFF);

    // Same operands unsigned: 253 * 5 = 0x04F1.
    drive(1'b1, 3'd5, 1'b0, 1'b0, 8'hFD, 8'h05, 1'b1);
    tick();
    for (int i = 0; i < WIDTH; i++) begin
      idle(1'b1);
      tick();
    end
    check("umul_y", out_y, 8'hF1);
    check("umul_y_hi", out_y_hi, 8'h04);

    // Backpressure: sub held for four cycles, then drained.
    drive(1'b1, 3'd1, 1'b0, 1'b0, 8'h05, 8'h07, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'd0, 1'b0, 1'b0, 8'h11, 8'h22, 1'b0);
      check("bp_ready", in_ready, 1'b0);
      tick();
      check("bp_valid", out_valid, 1'b1);
      check("bp_y", out_y, 8'hFE);
    end
    idle(1'b1);
    tick();
    check("bp_drained", out_valid, 1'b0);

    // Illegal opcode, then a legal op clears the error.
    drive(1'b1, 3'd7, 1'b1, 1'b0, 8'h3C, 8'hC3, 1'b1);
    tick();
    check("ill_err", out_err, 1'b1);
    check("ill_y", out_y, 8'h00);
    check("ill_y_hi", out_y_hi, 8'h00);
    drive(1'b1, 3'd0, 1'b0, 1'b0, 8'h01, 8'h01, 1'b1);
    tick();
    check("legal_err", out_err, 1'b0);
    check("legal_y", out_y, 8'h02);

    // Reset while the multiplier is at cnt==3.
    drive(1'b1, 3'd5, 1'b1, 1'b1, 8'hFD, 8'h05, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      tick();
    end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    idle(1'b1);
    check("midrst_ready", in_ready, 1'b1);
    check("midrst_valid", out_valid, 1'b0);
    for (int i = 0; i < WIDTH + 2; i++) begin
      idle(1'b1);
      tick();
    end

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
            1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
            ($urandom_range(0, 9) < 7));
      tick();
    end
    for (int i = 0; i < WIDTH + 2; i++) begin
      idle(1'b1);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pe_alu_seq.md
Name: pe_alu_seq

Overview:
- Parametrised, handshaked ALU for the PE tile. It is the sequential successor to the per-op combinational add/sub/and/or/xor/mul cells.
- One operation is in flight at a time. Opcode and signedness are selected per transaction.
- Logic and add/sub operations complete in one cycle. Multiply is iterative shift-add and returns the full double-width product.
- Sits between the PE operand muxes and the PE output register / routing.

Parameters:
- WIDTH, 8, operand and low-result width in bits (>=2).
- OPC_W, 3, opcode width; fixed encoding below.

Ports:
- UserCLK  input  1  tile clock; all state updates on rising edge.
- resetn  input  1  synchronous active-low reset, sampled on UserCLK rising edge.
- in_valid  input  1  operand/op valid.
- in_ready  output  1  block can accept a transaction this cycle.
- in_op  input  OPC_W  0=add 1=sub 2=and 3=or 4=xor 5=mul 6,7=illegal.
- in_a_signed  input  1  A is two's complement.
- in_b_signed  input  1  B is two's complement.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_y  output  WIDTH  result, low WIDTH bits.
- out_y_hi  output  WIDTH  upper product half for mul; 0 for all other ops.
- out_err  output  1  the transaction used an illegal opcode.

Behaviour:
- Reset: state=IDLE; out_valid=0, out_y=0, out_y_hi=0, out_err=0, in_ready=1. Reset dominates every other event. A reset asserted mid-multiply or while a result is held discards it; out_valid=0 from the next edge.
- Handshakes: accept when in_valid&&in_ready. Result transfers when out_valid&&out_ready. Inputs are sampled only on accept, and latched operands are used thereafter.
- in_ready = (state==IDLE) || (state==OUT && out_ready). Same-cycle drain and accept is legal; non-mul throughput is 1 op/cycle.
- State machine:
  - IDLE: on accept of a non-mul op, compute and register the result, then go to OUT. On accept of mul, go to MUL with cnt=0.
  - MUL: one shift-add step per cycle on the operand magnitudes; cnt increments. When cnt==WIDTH-1, finalise (negate the 2*WIDTH product if the signs differ), register it, and go to OUT. in_ready=0 throughout. in_valid is ignored.
  - OUT: out_valid=1; outputs stay stable until taken. On out_ready with no accept, go to IDLE. On out_ready with an accept, load the new op exactly as IDLE would.
- Latency, measured from the accept edge: non-mul out_valid is high after 1 edge; mul after WIDTH+1 edges.
- Arithmetic:
  - add/sub results are modulo 2^WIDTH; signedness does not change out_y.
  - and/or/xor are bitwise.
  - mul: the magnitude of a signed operand is |x|; the most-negative value has magnitude 2^(WIDTH-1), handled by treating the magnitude as unsigned WIDTH bits. The product is 2*WIDTH bits: {out_y_hi,out_y}.
  - Mixed signedness is legal. The product is negated iff (a_signed&&a[MSB]) XOR (b_signed&&b[MSB]).
- Illegal opcode: out_y=0, out_y_hi=0, out_err=1, with 1-cycle latency. out_err=0 for legal ops.
- out_valid is never deasserted without a transfer, except by reset.

Optional Feature:
- Macro PE_ALU_FLAGS_EN.
- When defined, three outputs are added, registered with the result and reset to 0:
  - out_zero (1 bit): out_y==0, and for mul also out_y_hi==0.
  - out_carry (1 bit): add gives the unsigned carry-out; sub gives 1 when there is no borrow (a>=b unsigned); 0 for other ops.
  - out_ovf (1 bit): signed overflow for add/sub when both operands are signed; for mul, set when the signed/unsigned 2*WIDTH product does not fit in WIDTH bits; 0 for other ops.
- When undefined, these ports and their logic are absent.
- All other behaviour is identical in both cases.

Test Plan (WIDTH=8):
- Reset: resetn=0 for 2 cycles, then 1 -> out_valid=0, out_y=0, out_err=0, in_ready=1.
- add 0xF0+0x20 -> out_y=0x10, out_y_hi=0 at accept+1; with flags, carry=1, zero=0. Back-to-back xor 0xAA^0xFF with out_ready=1 -> 0x55 on the next cycle (1 op/cycle).
- Mul latency and sign handling:
  - mul signed -3 (0xFD) * signed 5 -> after 9 edges, out_y=0xF1, out_y_hi=0xFF.
  - The same operands unsigned -> out_y=0xF1, out_y_hi=0x04.
  - in_ready=0 during MUL.
- Backpressure: sub 0x05-0x07 with out_ready=0 for 4 cycles -> out_y=0xFE held stable, out_valid=1, in_ready=0; transfer occurs on out_ready=1.
- Illegal op 7 -> out_err=1, out_y=0, out_y_hi=0; the next legal op clears out_err.
- Reset mid-mul: resetn=0 at cnt=3 -> IDLE next edge, out_valid never asserts for that op, in_ready=1.
